pipeline_debug_ctrl: RTL
========================

Name: pipeline_debug_ctrl

Overview:
- Sequences the pipelined MIPS datapath for debugging: gates the global pipeline enable for continuous run or single-step, and detects HALT.
- Shares the register file's debug read port to dump all 32 registers plus a cycle counter as a byte stream to the UART transmitter.
- Sits between the UART RX/TX byte interfaces and the pipeline top.
- Owns the register-file debug read address; WB write traffic is unaffected.

Parameters:
- N_REGS, 32, number of registers dumped; address width is 5.
- CMD_RUN, 8'h63, command byte for continuous run ('c').
- CMD_STEP, 8'h73, command byte for single step ('s').
- CMD_DUMP, 8'h72, command byte for register and counter dump ('r').
- CMD_CLEAR, 8'h78, command byte to clear the halted flag and cycle counter ('x').

Ports:
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command byte available from UART RX.
- i_cmd  in  8  command byte.
- o_cmd_ready  out  1  controller accepts a command this cycle.
- i_halt  in  1  HALT instruction retired in WB this cycle.
- o_pipe_enable  out  1  global pipeline clock enable (PC, all latches, reg file write).
- o_rf_dbg_addr  out  5  register-file debug read address.
- i_rf_dbg_data  in  32  register-file debug read data; combinational from the address.
- o_tx_valid  out  1  byte valid to UART TX.
- o_tx_data  out  8  byte to transmit.
- i_tx_ready  in  1  UART TX accepts the byte.
- o_halted  out  1  HALT seen; run and step are blocked.
- o_busy  out  1  high in any state other than IDLE.
- o_cycle_count  out  32  count of enabled pipeline cycles.

Behaviour:
- Reset (asynchronous, i_rst_n=0) forces these values:
  - state IDLE
  - o_pipe_enable=0, o_tx_valid=0, o_tx_data=0
  - o_rf_dbg_addr=0, o_halted=0, o_cycle_count=0, o_busy=0
  - o_cmd_ready=1 once reset is released.
- Reset mid-dump or mid-run aborts immediately. No partial byte is completed.
- States: IDLE, RUN, STEP, DUMP_RD, DUMP_TX, CNT_TX.
- Command acceptance:
  - o_cmd_ready=1 only in IDLE. A command is accepted when i_cmd_valid & o_cmd_ready.
  - Unknown bytes are consumed with no effect.
  - CMD_RUN or CMD_STEP with o_halted=1 is consumed with no effect.
- RUN:
  - Entered on the cycle after CMD_RUN is accepted.
  - o_pipe_enable=1 every cycle while in RUN.
  - When i_halt=1 is sampled: o_halted=1 and state goes to IDLE. o_pipe_enable=0 from the next cycle, so the HALT cycle itself is the last enabled cycle.
- STEP:
  - o_pipe_enable=1 for exactly one cycle, then IDLE.
  - If i_halt=1 during that cycle, o_halted=1.
- o_cycle_count:
  - +1 on every cycle with o_pipe_enable=1.
  - Saturates at 32'hFFFFFFFF.
  - CMD_CLEAR sets the counter to 0 and o_halted to 0. Both take effect the cycle after acceptance.
- Dump (CMD_DUMP):
  - o_pipe_enable=0 for the whole dump.
  - DUMP_RD: drives o_rf_dbg_addr=idx and latches i_rf_dbg_data into a 32-bit shift register. Takes one cycle.
  - DUMP_TX: o_tx_valid=1 with the byte MSB-first (bits 31:24 first). o_tx_valid and o_tx_data are held stable until i_tx_ready=1; on the handshake cycle the controller advances to the next byte.
  - After 4 bytes: idx+1 and back to DUMP_RD. After idx=31, go to CNT_TX.
  - CNT_TX: snapshot of o_cycle_count taken on entry, sent as 4 bytes MSB-first with the same handshake, then IDLE.
  - Total 132 bytes. idx does not wrap and resets to 0 at the start of each dump.
  - o_rf_dbg_addr keeps the last value driven when not dumping.
- Simultaneous events:
  - i_halt outside RUN/STEP is ignored.
  - i_tx_ready with o_tx_valid=0 is ignored.
  - A command is never accepted in the same cycle the controller leaves a busy state. IDLE must be registered first.

Test Plan:
- Reset, then CMD_STEP three times with i_halt=0 -> exactly 3 single-cycle o_pipe_enable pulses; o_cycle_count=3; o_cmd_ready=0 during each step.
- CMD_RUN, assert i_halt on the 10th enabled cycle -> o_pipe_enable high for 10 cycles then 0; o_halted=1; o_cycle_count=10. A following CMD_RUN is consumed, enable stays 0, count stays 10.
- CMD_DUMP with register model reg[k]=32'hA5000000+k, i_tx_ready always 1 -> 132 bytes; bytes 0..3 = A5,00,00,00; bytes 124..127 = A5,00,00,1F; last 4 bytes = the cycle count MSB-first.
- CMD_DUMP with i_tx_ready toggling randomly -> same byte sequence; o_tx_data never changes while o_tx_valid=1 and i_tx_ready=0.
- After a halt, send CMD_CLEAR then CMD_STEP -> o_halted=0, o_cycle_count=1. A byte 8'h00 is consumed with no state change.
- Assert i_rst_n=0 at byte 50 of a dump -> all outputs return to their reset values immediately; a new CMD_DUMP restarts from register 0.

Source files
------------

// File: rtl/pipeline_debug_ctrl.sv
// rtl/pipeline_debug_ctrl.sv - run/step/halt sequencing and register/cycle-count dump for the debug UART
module pipeline_debug_ctrl #(
    parameter int          N_REGS    = 32,
    parameter logic [7:0]  CMD_RUN   = 8'h63,
    parameter logic [7:0]  CMD_STEP  = 8'h73,
    parameter logic [7:0]  CMD_DUMP  = 8'h72,
    parameter logic [7:0]  CMD_CLEAR = 8'h78
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    input  logic [7:0]  i_cmd,
    output logic        o_cmd_ready,
    input  logic        i_halt,
    output logic        o_pipe_enable,
    output logic [4:0]  o_rf_dbg_addr,
    input  logic [31:0] i_rf_dbg_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_halted,
    output logic        o_busy,
    output logic [31:0] o_cycle_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        STEP    = 3'd2,
        DUMP_RD = 3'd3,
        DUMP_TX = 3'd4,
        CNT_TX  = 3'd5
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(N_REGS - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] shift_q;
    logic [31:0] count_q;
    logic [4:0]  addr_q;
    logic [1:0]  byte_q;
    logic        halted_q;
    logic        accept;
    logic        tx_fire;
    logic        last_byte;

    assign o_cmd_ready   = (state == IDLE) && i_rst_n;
    assign o_pipe_enable = (state == RUN) || (state == STEP);
    assign o_tx_valid    = (state == DUMP_TX) || (state == CNT_TX);
    assign o_tx_data     = shift_q[31:24];
    assign o_busy        = (state != IDLE);
    assign o_rf_dbg_addr = addr_q;
    assign o_halted      = halted_q;
    assign o_cycle_count = count_q;

    assign accept    = i_cmd_valid && o_cmd_ready;
    assign tx_fire   = o_tx_valid && i_tx_ready;
    assign last_byte = (byte_q == 2'd3);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (i_cmd == CMD_RUN && !halted_q) begin
                        state_next = RUN;
                    end else if (i_cmd == CMD_STEP && !halted_q) begin
                        state_next = STEP;
                    end else if (i_cmd == CMD_DUMP) begin
                        state_next = DUMP_RD;
                    end
                end
            end
            RUN: begin
                if (i_halt) begin
                    state_next = IDLE;
                end
            end
            STEP:    state_next = IDLE;
            DUMP_RD: state_next = DUMP_TX;
            DUMP_TX: begin
                if (tx_fire && last_byte) begin
                    state_next = (addr_q == LAST_IDX) ? CNT_TX : DUMP_RD;
                end
            end
            CNT_TX: begin
                if (tx_fire && last_byte) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // addr_q doubles as the dump register index; it is left untouched outside a dump.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q  <= 32'd0;
            count_q  <= 32'd0;
            addr_q   <= 5'd0;
            byte_q   <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            if (o_pipe_enable && count_q != 32'hFFFF_FFFF) begin
                count_q <= count_q + 32'd1;
            end
            if (o_pipe_enable && i_halt) begin
                halted_q <= 1'b1;
            end
            if (accept && i_cmd == CMD_CLEAR) begin
                count_q  <= 32'd0;
                halted_q <= 1'b0;
            end
            if (accept && i_cmd == CMD_DUMP) begin
                addr_q <= 5'd0;
                byte_q <= 2'd0;
            end
            if (state == DUMP_RD) begin
                shift_q <= i_rf_dbg_data;
            end
            if (tx_fire) begin
                shift_q <= shift_q << 8;
                byte_q  <= byte_q + 2'd1;
                // Counter snapshot is loaded as the last register's final byte leaves.
                if (last_byte && state == DUMP_TX) begin
                    if (addr_q == LAST_IDX) begin
                        shift_q <= count_q;
                    end else begin
                        addr_q <= addr_q + 5'd1;
                    end
                end
            end
        end
    end

endmodule
